ram_port_arbiter: RTL and testbench

- Shares the single 8-bit parameter/image RAM port between three requesters:
  - the parameter loader, which writes 16-bit words;
  - the image decompressor, which writes bytes;
  - the CNN core, which reads bytes.
- Sits between the coordinator's requesters and the RAM.
- Splits each 16-bit word into two byte writes, big-endian: high byte at addr, low byte at addr+1.
- Round-robin arbitration; every transaction is atomic.

---
 rtl/dcnn_io_pkg.sv | 25 ++
 rtl/rr_pick3.sv | 26 ++
 rtl/ram_port_arbiter.sv | 138 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcnn_io_pkg.sv
// Shared types and constants for the parameter/image RAM port arbiter.
package dcnn_io_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned BYTE_W_DEF = 8;

    localparam logic [1:0] REQ_LD   = 2'd0;
    localparam logic [1:0] REQ_DC   = 2'd1;
    localparam logic [1:0] REQ_CORE = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        WR_HI,
        WR_LO,
        WR_B,
        RD,
        RD_WAIT
    } state_t;

    // Requester that follows idx in the circular order L, D, C.
    function automatic logic [1:0] req_next(input logic [1:0] idx);
        return (idx == REQ_CORE) ? REQ_LD : 2'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way picker: round-robin after 'last', or fixed L > D > C priority.
module rr_pick3
    import dcnn_io_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    input  logic       rr_en,
    output logic [2:0] grant,
    output logic       valid
);

    logic [1:0] start;

    always_comb begin
        start = rr_en ? req_next(last) : REQ_LD;
        grant = 3'b000;
        valid = |req;
        // Search begins at 'start' and wraps through the remaining two.
        case (start)
            REQ_DC:   grant = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
            REQ_CORE: grant = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
            default:  grant = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one byte-wide RAM port between the word loader, the byte decompressor
// and the CNN core reader; every transaction runs to completion once granted.
module ram_port_arbiter
    import dcnn_io_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYTE_W = BYTE_W_DEF,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                interrupt,
    input  logic                ld_req,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [2*BYTE_W-1:0] ld_data,
    output logic                ld_gnt,
    input  logic                dc_req,
    input  logic [ADDR_W-1:0]   dc_addr,
    input  logic [BYTE_W-1:0]   dc_data,
    output logic                dc_gnt,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [BYTE_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic [ADDR_W-1:0]   ramAddress,
    output logic [BYTE_W-1:0]   ramDataIn,
    input  logic [BYTE_W-1:0]   ramDataOut,
    output logic                readSignal,
    output logic                writeSignal,
    output logic                busy
);

    state_t              state_q, state_d;
    logic [1:0]          last_q, last_d;
    logic [2:0]          pick_gnt;
    logic                pick_valid;

    logic [ADDR_W-1:0]   addr_d;
    logic [BYTE_W-1:0]   din_d;
    logic [BYTE_W-1:0]   rd_data_d;
    logic                wr_d, rd_d, ld_gnt_d, dc_gnt_d, rd_valid_d, busy_d;

    rr_pick3 u_pick (
        .req   ({rd_req, dc_req, ld_req}),
        .last  (last_q),
        .rr_en (RR_EN),
        .grant (pick_gnt),
        .valid (pick_valid)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        addr_d     = ramAddress;
        din_d      = ramDataIn;
        rd_data_d  = rd_data;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        ld_gnt_d   = 1'b0;
        dc_gnt_d   = 1'b0;
        rd_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!interrupt && pick_valid) begin
                    if (pick_gnt[0]) begin
                        state_d = WR_HI;
                        last_d  = REQ_LD;
                        addr_d  = ld_addr;
                        din_d   = ld_data[2*BYTE_W-1:BYTE_W];
                        wr_d    = 1'b1;
                    end else if (pick_gnt[1]) begin
                        state_d  = WR_B;
                        last_d   = REQ_DC;
                        addr_d   = dc_addr;
                        din_d    = dc_data;
                        wr_d     = 1'b1;
                        dc_gnt_d = 1'b1;
                    end else begin
                        state_d = RD;
                        last_d  = REQ_CORE;
                        addr_d  = rd_addr;
                        rd_d    = 1'b1;
                    end
                end
            end
            WR_HI: begin
                state_d  = WR_LO;
                addr_d   = ADDR_W'(ld_addr + ADDR_W'(1));
                din_d    = ld_data[BYTE_W-1:0];
                wr_d     = 1'b1;
                ld_gnt_d = 1'b1;
            end
            WR_LO:   state_d = IDLE;
            WR_B:    state_d = IDLE;
            RD: begin
                state_d    = RD_WAIT;
                rd_data_d  = ramDataOut;
                rd_valid_d = 1'b1;
            end
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, round-robin pointer and all outputs; reset leaves the pointer at the loader.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            last_q      <= REQ_CORE;
            ramAddress  <= '0;
            ramDataIn   <= '0;
            rd_data     <= '0;
            writeSignal <= 1'b0;
            readSignal  <= 1'b0;
            ld_gnt      <= 1'b0;
            dc_gnt      <= 1'b0;
            rd_valid    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            ramAddress  <= addr_d;
            ramDataIn   <= din_d;
            rd_data     <= rd_data_d;
            writeSignal <= wr_d;
            readSignal  <= rd_d;
            ld_gnt      <= ld_gnt_d;
            dc_gnt      <= dc_gnt_d;
            rd_valid    <= rd_valid_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a byte RAM model and a fixed-priority twin.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        interrupt = 1'b0;
    logic        ld_req = 1'b0, dc_req = 1'b0, rd_req = 1'b0;
    logic [15:0] ld_addr = '0, dc_addr = '0, rd_addr = '0;
    logic [15:0] ld_data = '0;
    logic [7:0]  dc_data = '0;
    logic        ld_gnt, dc_gnt, rd_valid, readSignal, writeSignal, busy;
    logic [7:0]  rd_data, ramDataIn;
    logic [7:0]  ramDataOut = '0;
    logic [15:0] ramAddress;

    logic        fp_ld_req = 1'b0, fp_dc_req = 1'b0, fp_rd_req = 1'b0;
    logic        fp_ld_gnt, fp_dc_gnt, fp_rd_valid, fp_rs, fp_ws, fp_busy;
    logic [7:0]  fp_rd_data, fp_din;
    logic [15:0] fp_addr;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(16), .BYTE_W(8), .RR_EN(1'b1)) dut (
        .clk(clk), .RST(rst), .interrupt(interrupt),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_data(dc_data), .dc_gnt(dc_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .ramAddress(ramAddress), .ramDataIn(ramDataIn), .ramDataOut(ramDataOut),
        .readSignal(readSignal), .writeSignal(writeSignal), .busy(busy)
    );

    ram_port_arbiter #(.ADDR_W(16), .BYTE_W(8), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .RST(rst), .interrupt(interrupt),
        .ld_req(fp_ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(fp_ld_gnt),
        .dc_req(fp_dc_req), .dc_addr(dc_addr), .dc_data(dc_data), .dc_gnt(fp_dc_gnt),
        .rd_req(fp_rd_req), .rd_addr(rd_addr), .rd_data(fp_rd_data), .rd_valid(fp_rd_valid),
        .ramAddress(fp_addr), .ramDataIn(fp_din), .ramDataOut(8'h00),
        .readSignal(fp_rs), .writeSignal(fp_ws), .busy(fp_busy)
    );

    // Byte RAM model; read data is returned within the strobe cycle.
    logic [7:0] mem [0:65535];
    int   wr_total = 0;
    int   rd_total = 0;
    logic both_seen = 1'b0;

    always @(posedge clk) begin
        if (writeSignal) mem[ramAddress] <= ramDataIn;
        if (writeSignal) wr_total <= wr_total + 1;
        if (readSignal)  rd_total <= rd_total + 1;
        if (writeSignal && readSignal) both_seen <= 1'b1;
    end

    always @(negedge clk) if (readSignal) ramDataOut <= mem[ramAddress];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ld_word(input logic [15:0] a, input logic [15:0] d, output int lat, output int nbusy);
        lat = -1; nbusy = 0;
        ld_addr = a; ld_data = d; ld_req = 1'b1;
        for (int c = 0; c < 12 && lat < 0; c++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (ld_gnt) lat = c;
        end
        @(posedge clk); #1;
        ld_req = 1'b0;
    endtask

    task automatic dc_byte(input logic [15:0] a, input logic [7:0] d, output int lat);
        lat = -1;
        dc_addr = a; dc_data = d; dc_req = 1'b1;
        for (int c = 0; c < 12 && lat < 0; c++) begin
            @(negedge clk);
            if (dc_gnt) lat = c;
        end
        @(posedge clk); #1;
        dc_req = 1'b0;
    endtask

    // Cycle loop with optional interrupt/reset/late-dc events; requesters drop on grant.
    task automatic run_cycles(input int n, input int int_on, input int int_off,
                              input int rst_on, input int rst_off, input int dc_on,
                              output int t_ld, output int t_dc, output int t_rd,
                              output int n_gnt, output logic [7:0] rd_got);
        logic s_ld, s_dc, s_rd;
        t_ld = -1; t_dc = -1; t_rd = -1; n_gnt = 0; rd_got = '0;
        for (int c = 0; c < n; c++) begin
            if (c == int_on)  interrupt = 1'b1;
            if (c == int_off) interrupt = 1'b0;
            if (c == dc_on)   dc_req = 1'b1;
            if (c == rst_off) rst = 1'b0;
            if (c == rst_on) begin
                rst = 1'b1;
                #1;
                check("rst_mid_busy", 32'(busy), 32'h0);
                check("rst_mid_wr", 32'(writeSignal), 32'h0);
                check("rst_mid_gnt", 32'(ld_gnt), 32'h0);
                check("rst_mid_addr", 32'(ramAddress), 32'h0);
                check("rst_mid_din", 32'(ramDataIn), 32'h0);
                check("rst_mid_rdata", 32'(rd_data), 32'h0);
            end
            @(negedge clk);
            s_ld = ld_gnt; s_dc = dc_gnt; s_rd = rd_valid;
            if (s_ld && t_ld < 0) t_ld = c;
            if (s_dc && t_dc < 0) t_dc = c;
            if (s_rd && t_rd < 0) t_rd = c;
            if (s_rd) rd_got = rd_data;
            n_gnt += int'(s_ld) + int'(s_dc) + int'(s_rd);
            @(posedge clk); #1;
            if (s_ld) ld_req = 1'b0;
            if (s_dc) dc_req = 1'b0;
            if (s_rd) rd_req = 1'b0;
        end
    endtask

    initial begin
        int lat, nb, t_ld, t_dc, t_rd, n_gnt, nl, fp_t, ld_before, wr0, rd0, bad_lat, bad_mem;
        logic [7:0] got;
        logic s_l, s_d;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_strobes", 32'({writeSignal, readSignal}), 32'h0);
        check("reset_pulses", 32'({ld_gnt, dc_gnt, rd_valid}), 32'h0);
        check("reset_addr", 32'(ramAddress), 32'h0);
        check("reset_din", 32'(ramDataIn), 32'h0);
        check("reset_rdata", 32'(rd_data), 32'h0);
        rst = 1'b0;

        ld_word(16'h000E, 16'hA55A, lat, nb);
        check("word_gnt_lat", 32'(lat), 32'd2);
        check("word_busy_cycles", 32'(nb), 32'd2);
        @(negedge clk);
        check("word_hi", 32'(mem[16'h000E]), 32'hA5);
        check("word_lo", 32'(mem[16'h000F]), 32'h5A);
        @(posedge clk); #1;

        ld_word(16'hFFFF, 16'h1234, lat, nb);
        @(negedge clk);
        check("wrap_hi", 32'(mem[16'hFFFF]), 32'h12);
        check("wrap_lo", 32'(mem[16'h0000]), 32'h34);
        @(posedge clk); #1;

        // Preload the read target, then restart from reset for the contention case.
        dc_byte(16'h0002, 8'h12, lat);
        check("byte_gnt_lat", 32'(lat), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        ld_addr = 16'h0020; ld_data = 16'hBEEF;
        dc_addr = 16'h0030; dc_data = 8'h77;
        rd_addr = 16'h0002;
        ld_req = 1'b1; dc_req = 1'b1; rd_req = 1'b1;
        run_cycles(10, -1, -1, -1, -1, -1, t_ld, t_dc, t_rd, n_gnt, got);
        check("cont_ld_cycle", 32'(t_ld), 32'd2);
        check("cont_dc_cycle", 32'(t_dc), 32'd4);
        check("cont_rd_cycle", 32'(t_rd), 32'd7);
        check("cont_rd_data", 32'(got), 32'h12);
        check("cont_grants", 32'(n_gnt), 32'd3);
        check("cont_mem_ld", 32'(mem[16'h0021]), 32'hEF);
        check("cont_mem_dc", 32'(mem[16'h0030]), 32'h77);

        // Fixed priority: loader re-requests three times before the decompressor is served.
        fp_ld_req = 1'b1; fp_dc_req = 1'b1;
        nl = 0; fp_t = -1; ld_before = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            s_l = fp_ld_gnt; s_d = fp_dc_gnt;
            if (s_l) nl++;
            if (s_d && fp_t < 0) begin fp_t = c; ld_before = nl; end
            @(posedge clk); #1;
            if (s_l && nl == 3) fp_ld_req = 1'b0;
            if (s_d) fp_dc_req = 1'b0;
        end
        check("fp_ld_before_dc", 32'(ld_before), 32'd3);
        check("fp_dc_cycle", 32'(fp_t), 32'd10);
        check("fp_busy_end", 32'(fp_busy), 32'h0);

        ld_addr = 16'h0040; ld_data = 16'hCAFE;
        dc_addr = 16'h0050; dc_data = 8'h99;
        ld_req = 1'b1; dc_req = 1'b1;
        run_cycles(12, 1, 7, -1, -1, -1, t_ld, t_dc, t_rd, n_gnt, got);
        check("int_ld_cycle", 32'(t_ld), 32'd2);
        check("int_dc_cycle", 32'(t_dc), 32'd8);
        check("int_grants", 32'(n_gnt), 32'd2);
        check("int_mem_lo", 32'(mem[16'h0041]), 32'hFE);
        check("int_mem_dc", 32'(mem[16'h0050]), 32'h99);
        check("rd_data_held", 32'(rd_data), 32'h12);

        // Leave the pointer just past the loader so only a reset can put it back.
        ld_word(16'h0070, 16'h0BAD, lat, nb);
        ld_addr = 16'h0060; ld_data = 16'h5678;
        dc_addr = 16'h0062; dc_data = 8'h44;
        ld_req = 1'b1;
        run_cycles(12, -1, -1, 2, 4, 2, t_ld, t_dc, t_rd, n_gnt, got);
        check("rst_ld_cycle", 32'(t_ld), 32'd6);
        check("rst_dc_cycle", 32'(t_dc), 32'd8);
        check("rst_mem_lo", 32'(mem[16'h0061]), 32'h78);

        wr0 = wr_total; rd0 = rd_total; bad_lat = 0; bad_mem = 0;
        for (int i = 0; i < 34; i++) begin
            dc_byte(16'(16'h0100 + i), 8'(i * 7 + 3), lat);
            if (lat != 1) bad_lat++;
        end
        @(negedge clk);
        for (int i = 0; i < 34; i++)
            if (mem[16'(16'h0100 + i)] !== 8'(i * 7 + 3)) bad_mem++;
        check("stream_bad_lat", 32'(bad_lat), 32'd0);
        check("stream_bad_mem", 32'(bad_mem), 32'd0);
        check("stream_writes", 32'(wr_total - wr0), 32'd34);
        check("stream_reads", 32'(rd_total - rd0), 32'd0);
        check("strobe_overlap", 32'(both_seen), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
